// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the ARM-subset core: sequences the shared ALU, memory
// port and immediate extender, holds the NZCV flag register and evaluates condition codes.
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic [1:0]  reg_src,
  output logic [3:0]  flags_q,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  nzcv_q, nzcv_d;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [3:0]  cond;
  logic        mem_rdy;
  logic        cond_ex;
  logic        dp_legal;
  logic        dp_cmp;
  logic [1:0]  dp_alu;
  logic        unused_instr_bits;

  // Condition-code evaluation against {N,Z,C,V}; the 1111 code never executes.
  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_check = z;
      4'b0001: cond_check = !z;
      4'b0010: cond_check = cf;
      4'b0011: cond_check = !cf;
      4'b0100: cond_check = n;
      4'b0101: cond_check = !n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = !v;
      4'b1000: cond_check = cf & !z;
      4'b1001: cond_check = !cf | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = !z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  assign op                = instr[27:26];
  assign funct             = instr[25:20];
  assign rd                = instr[15:12];
  assign cond              = instr[31:28];
  assign unused_instr_bits = ^{instr[19:16], instr[11:0]};
  assign mem_rdy           = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign cond_ex           = cond_check(cond, nzcv_q);
  assign flags_q           = reset ? 4'b0000 : nzcv_q;

  // Data-processing command decode: ALU op, compare flag and legality.
  always_comb begin
    dp_alu   = 2'b00;
    dp_legal = 1'b1;
    dp_cmp   = 1'b0;
    case (funct[4:1])
      4'b0100: dp_alu = 2'b00;
      4'b0010: dp_alu = 2'b01;
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      4'b1010: begin
        dp_alu = 2'b01;
        dp_cmp = 1'b1;
      end
      default: dp_legal = 1'b0;
    endcase
  end

  // Next-state, flag update and Moore control outputs; everything held at zero in reset.
  always_comb begin
    state_d     = state_q;
    nzcv_d      = nzcv_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 2'b00;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    illegal     = 1'b0;
    if (reset) begin
      state_d = S_FETCH;
      nzcv_d  = 4'b0000;
    end else begin
      if (state_q != S_FETCH) begin
        imm_src = (op == 2'b11) ? 2'b00 : op;
      end else begin
        imm_src = 2'b00;
      end
      case (state_q)
        S_FETCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_rdy;
          pc_write   = mem_rdy;
          if (mem_rdy) begin
            state_d = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          alu_src_a  = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          reg_src    = {(op == 2'b01) & !funct[0], (op == 2'b10)};
          case (op)
            2'b00: begin
              if (!dp_legal) begin
                illegal = 1'b1;
                state_d = S_FETCH;
              end else if (funct[5]) begin
                state_d = S_EXECI;
              end else begin
                state_d = S_EXECR;
              end
            end
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_b = 2'b01;
          state_d   = funct[0] ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          adr_src = 1'b1;
          if (mem_rdy) begin
            state_d = S_MEMWB;
          end else begin
            state_d = S_MEMRD;
          end
        end
        S_MEMWR: begin
          adr_src   = 1'b1;
          mem_write = cond_ex & mem_rdy;
          if (mem_rdy) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_MEMWR;
          end
        end
        S_MEMWB: begin
          result_src = 2'b01;
          if (cond_ex) begin
            pc_write  = (rd == 4'd15);
            reg_write = (rd != 4'd15);
          end else begin
            reg_write = 1'b0;
          end
          state_d = S_FETCH;
        end
        S_EXECR, S_EXECI: begin
          alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
          alu_control = dp_alu;
          if (cond_ex & (funct[0] | dp_cmp)) begin
            nzcv_d = alu_flags;
          end else begin
            nzcv_d = nzcv_q;
          end
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          // compares only update flags, so they never reach a write enable
          if (cond_ex & !dp_cmp) begin
            pc_write  = (rd == 4'd15);
            reg_write = (rd != 4'd15);
          end else begin
            reg_write = 1'b0;
          end
          state_d = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_b  = 2'b01;
          result_src = 2'b10;
          pc_write   = cond_ex;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      nzcv_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      nzcv_q  <= nzcv_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors for each
// instruction class, flag updates, condition handling, illegal decode and reset.
module tb_multicycle_controller;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        mem_ready;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]  result_src, alu_src_b, alu_control, imm_src, reg_src;
  logic        alu_src_a, illegal;
  logic [3:0]  flags_q;
  logic [16:0] ctl;
  int          checks = 0;
  int          failures = 0;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
  //  alu_src_b, alu_control, imm_src, reg_src, illegal}
  localparam logic [16:0] F1 = 17'b1_0_0_1_0_10_1_10_00_00_00_0;
  localparam logic [16:0] F0 = 17'b0_0_0_0_0_10_1_10_00_00_00_0;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src),
    .flags_q(flags_q), .illegal(illegal)
  );

  assign ctl = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_control, imm_src, reg_src, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] mk(input logic pc, input logic adr, input logic mw,
                                     input logic ir, input logic rw, input logic [1:0] rs,
                                     input logic sa, input logic [1:0] sb, input logic [1:0] ac,
                                     input logic [1:0] is, input logic [1:0] rg, input logic il);
    return {pc, adr, mw, ir, rw, rs, sa, sb, ac, is, rg, il};
  endfunction

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; instr = 32'h0; alu_flags = 4'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 17'h0) begin failures++; $display("FAIL reset_ctl cyc%0d got %h exp %h", i, ctl, 17'h0); end
      checks++;
      if (flags_q !== 4'b0000) begin failures++; $display("FAIL reset_flags cyc%0d got %b exp 0000", i, flags_q); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_add_imm();
    logic [16:0] ex [4];
    ex = '{F1,
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b00,2'b00,1'b0),
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b00,2'b00,1'b0),
           mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0)};
    instr = 32'hE2811005;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (ctl !== ex[i]) begin failures++; $display("FAIL add_imm cyc%0d got %h exp %h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (ctl !== F1) begin failures++; $display("FAIL add_back_to_fetch got %h exp %h", ctl, F1); end
    checks++;
    if (flags_q !== 4'b0000) begin failures++; $display("FAIL add_flags got %b exp 0000", flags_q); end
  endtask

  task automatic test_ldr_wait();
    logic [16:0] ex [8];
    logic        mr [8];
    logic [16:0] rd_v;
    rd_v = mk(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0);
    ex = '{F0, F1,
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b01,2'b00,1'b0),
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b01,2'b00,1'b0),
           rd_v, rd_v, rd_v,
           mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0)};
    mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    instr = 32'hE5912004;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (ctl !== ex[i]) begin failures++; $display("FAIL ldr_wait cyc%0d got %h exp %h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_store();
    logic [16:0] ex [5];
    logic        mr [5];
    ex = '{F1,
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b01,2'b10,1'b0),
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b01,2'b00,1'b0),
           mk(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0),
           mk(1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0)};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    instr = 32'hE5812004;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (ctl !== ex[i]) begin failures++; $display("FAIL store cyc%0d got %h exp %h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_cmp();
    logic [16:0] ex [4];
    ex = '{F1,
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b00,2'b00,1'b0),
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b01,2'b00,2'b00,1'b0),
           17'h0};
    instr = 32'hE1510002;
    alu_flags = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; #1;
      checks++;
      if (ctl !== ex[i]) begin failures++; $display("FAIL cmp cyc%0d got %h exp %h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
    checks++;
    if (flags_q !== 4'b0100) begin failures++; $display("FAIL cmp_flags got %b exp 0100", flags_q); end
    alu_flags = 4'b0000;
  endtask

  task automatic test_branch();
    logic [31:0] ins [2];
    logic        pcx [2];
    logic [16:0] ex  [3];
    ins = '{32'h0A000002, 32'h1A000002};
    pcx = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      ex = '{F1,
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b10,2'b01,1'b0),
             mk(pcx[k],1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,2'b01,2'b00,2'b10,2'b00,1'b0)};
      instr = ins[k];
      for (int i = 0; i < 3; i++) begin
        mem_ready = 1'b1; #1;
        checks++;
        if (ctl !== ex[i]) begin failures++; $display("FAIL branch%0d cyc%0d got %h exp %h", k, i, ctl, ex[i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_writeback_cond();
    logic [31:0] ins [3];
    logic [16:0] wb  [3];
    logic [3:0]  af  [3];
    logic [16:0] ex  [4];
    ins = '{32'hE281F005, 32'h12811005, 32'hE2911005};
    wb  = '{mk(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0),
            17'h0,
            mk(1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0)};
    af  = '{4'b0000, 4'b0000, 4'b1001};
    checks++;
    if (flags_q !== 4'b0100) begin failures++; $display("FAIL wb_flags_before got %b exp 0100", flags_q); end
    for (int k = 0; k < 3; k++) begin
      ex = '{F1,
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b00,2'b00,1'b0),
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b00,2'b00,1'b0),
             wb[k]};
      instr = ins[k];
      alu_flags = af[k];
      for (int i = 0; i < 4; i++) begin
        mem_ready = 1'b1; #1;
        checks++;
        if (ctl !== ex[i]) begin failures++; $display("FAIL wb%0d cyc%0d got %h exp %h", k, i, ctl, ex[i]); end
        @(posedge clk); #1;
      end
    end
    checks++;
    if (flags_q !== 4'b1001) begin failures++; $display("FAIL adds_flags got %b exp 1001", flags_q); end
    alu_flags = 4'b0000;
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    logic [16:0] ex  [2];
    ins = '{32'hEC000000, 32'hE2211005};
    ex  = '{F1, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b00,2'b00,1'b1)};
    for (int k = 0; k < 2; k++) begin
      instr = ins[k];
      for (int i = 0; i < 2; i++) begin
        mem_ready = 1'b1; #1;
        checks++;
        if (ctl !== ex[i]) begin failures++; $display("FAIL illegal%0d cyc%0d got %h exp %h", k, i, ctl, ex[i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_memwr();
    logic [16:0] ex [4];
    logic        mr [4];
    ex = '{F1,
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,2'b10,2'b00,2'b01,2'b10,1'b0),
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,2'b01,2'b00,1'b0),
           mk(1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0)};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0};
    instr = 32'hE5812004;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i]; #1;
      checks++;
      if (ctl !== ex[i]) begin failures++; $display("FAIL rst_str cyc%0d got %h exp %h", i, ctl, ex[i]); end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if (ctl !== 17'h0) begin failures++; $display("FAIL rst_memwr_ctl got %h exp %h", ctl, 17'h0); end
    checks++;
    if (flags_q !== 4'b0000) begin failures++; $display("FAIL rst_memwr_flags got %b exp 0000", flags_q); end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    checks++;
    if (ctl !== F1) begin failures++; $display("FAIL rst_release_fetch got %h exp %h", ctl, F1); end
    checks++;
    if (flags_q !== 4'b0000) begin failures++; $display("FAIL rst_release_flags got %b exp 0000", flags_q); end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_ldr_wait();
    test_store();
    test_cmp();
    test_branch();
    test_writeback_cond();
    test_illegal();
    test_reset_memwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
